ring_seq_checker: RTL and testbench



---
 rtl/ring_seq_checker.sv | 153 +++++++++++++++
 tb/tb_ring_seq_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_seq_checker.sv
// ============================================================================
// ring_seq_checker : one-hot ring counter sequence monitor (lock/rev/error)
// Revision 1.0
// ============================================================================
`default_nettype none

module ring_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_phase,
    input  logic               in_valid,
    input  logic               err_clr,
    output logic               locked,
    output logic               err,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [REV_W-1:0]   rev_cnt,
    output logic [IDX_W-1:0]   phase_idx
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] C_LOCK = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_prev;
    logic [GOOD_W-1:0]  r_good;
    logic               r_locked;
    logic               r_err;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [REV_W-1:0]   r_rev_cnt;
    logic [IDX_W-1:0]   r_phase_idx;

    logic [WIDTH-1:0]   w_rotl;
    logic [WIDTH-1:0]   w_phase_m1;
    logic               w_onehot;
    logic               w_legal;
    logic [IDX_W-1:0]   w_idx;
    logic [GOOD_W-1:0]  w_good_inc;

    assign w_rotl     = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_phase_m1 = in_phase - WIDTH'(1);
    assign w_onehot   = (in_phase != '0) && ((in_phase & w_phase_m1) == '0);
    // r_prev is never zero once compared here, so equality implies one-hot
    assign w_legal    = w_onehot && (in_phase == w_rotl);
    assign w_good_inc = r_good + GOOD_W'(1);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_phase[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_prev      <= '0;
            r_good      <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_rev_cnt   <= '0;
            r_phase_idx <= '0;
        end else begin
            // A fault detected below on the same edge overrides this clear
            if (err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_HUNT: begin
                    if (in_valid && w_onehot) begin
                        r_prev      <= in_phase;
                        r_phase_idx <= w_idx;
                        r_good      <= '0;
                        r_state     <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    if (in_valid) begin
                        if (!w_onehot) begin
                            r_state <= S_HUNT;
                        end else if (w_legal) begin
                            r_prev      <= in_phase;
                            r_phase_idx <= w_idx;
                            r_good      <= w_good_inc;
                            if (w_good_inc == C_LOCK) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_prev      <= in_phase;
                            r_phase_idx <= w_idx;
                            r_good      <= '0;
                        end
                    end
                end

                S_LOCKED: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_prev      <= in_phase;
                            r_phase_idx <= w_idx;
                            if (in_phase[0]) begin
                                r_rev_cnt <= r_rev_cnt + REV_W'(1);
                            end
                        end else begin
                            r_state  <= S_FAULT;
                            r_locked <= 1'b0;
                            r_err    <= 1'b1;
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                        end
                    end
                end

                S_FAULT: begin
                    r_state <= S_HUNT;
                end

                default: begin
                    r_state  <= S_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign rev_cnt   = r_rev_cnt;
    assign phase_idx = r_phase_idx;

endmodule

`default_nettype wire

// File: tb/tb_ring_seq_checker.sv
// ============================================================================
// tb_ring_seq_checker : directed self-checking bench for ring_seq_checker
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ring_seq_checker;

    logic       clk;
    logic       rst;
    logic [3:0] in_phase;
    logic       in_valid;
    logic       err_clr;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] rev_cnt;
    logic [1:0] phase_idx;

    int n_checks;
    int n_fail;
    int exp_err;
    int exp_rev;

    ring_seq_checker #(
        .WIDTH    (4),
        .LOCK_CNT (4),
        .REV_W    (8),
        .ERR_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_phase  (in_phase),
        .in_valid  (in_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .rev_cnt   (rev_cnt),
        .phase_idx (phase_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic [3:0] ph, input logic v, input logic clr);
        @(negedge clk);
        in_phase = ph;
        in_valid = v;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    // Five legal samples starting at 0001, ending locked with prev=0001.
    task automatic relock();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_phase = 4'b0001; in_valid = 1'b1; err_clr = 1'b0;
        #2;
        n_checks++;
        if ({locked, err, err_cnt, rev_cnt, phase_idx} !== 19'd0) begin
            $display("FAIL reset_async: got %b required 0", {locked, err, err_cnt, rev_cnt, phase_idx});
            n_fail++;
        end
        @(posedge clk); #1;
        n_checks++;
        if ({locked, err, err_cnt, rev_cnt, phase_idx} !== 19'd0) begin
            $display("FAIL reset_held: got %b required 0", {locked, err, err_cnt, rev_cnt, phase_idx});
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_lock();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if (phase_idx !== 2'd1) begin
            $display("FAIL lock_idx2: got %0d required 1", phase_idx); n_fail++;
        end
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            $display("FAIL lock_early: got %b required 0", locked); n_fail++;
        end
        step(4'b0001, 1'b1, 1'b0);
        n_checks++;
        if ({locked, rev_cnt, phase_idx} !== {1'b1, 8'd0, 2'd0}) begin
            $display("FAIL lock_5th: got locked=%b rev=%0d idx=%0d required 1/0/0", locked, rev_cnt, phase_idx);
            n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            step(4'b0010, 1'b1, 1'b0);
            step(4'b0100, 1'b1, 1'b0);
            step(4'b1000, 1'b1, 1'b0);
            step(4'b0001, 1'b1, 1'b0);
        end
        n_checks++;
        if ({locked, err, rev_cnt, phase_idx} !== {1'b1, 1'b0, 8'd2, 2'd0}) begin
            $display("FAIL lock_laps: got locked=%b err=%b rev=%0d idx=%0d required 1/0/2/0", locked, err, rev_cnt, phase_idx);
            n_fail++;
        end
    endtask

    task automatic test_bad_onehot();
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        n_checks++;
        if ({locked, err, err_cnt, phase_idx} !== {1'b0, 1'b1, 8'd1, 2'd1}) begin
            $display("FAIL bad_onehot: got locked=%b err=%b cnt=%0d idx=%0d required 0/1/1/1", locked, err, err_cnt, phase_idx);
            n_fail++;
        end
        step(4'b0100, 1'b1, 1'b0);
        n_checks++;
        if ({locked, phase_idx} !== {1'b0, 2'd1}) begin
            $display("FAIL fault_ignore: got locked=%b idx=%0d required 0/1", locked, phase_idx);
            n_fail++;
        end
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            $display("FAIL relock_early: got %b required 0", locked); n_fail++;
        end
        step(4'b0100, 1'b1, 1'b0);
        n_checks++;
        if ({locked, rev_cnt, err} !== {1'b1, 8'd2, 1'b1}) begin
            $display("FAIL relock: got locked=%b rev=%0d err=%b required 1/2/1", locked, rev_cnt, err);
            n_fail++;
        end
        step(4'b1111, 1'b0, 1'b1);
        n_checks++;
        if ({locked, err, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            $display("FAIL clr_locked: got locked=%b err=%b cnt=%0d required 1/0/1", locked, err, err_cnt);
            n_fail++;
        end
    endtask

    task automatic test_mid_reset();
        step(4'b0001, 1'b1, 1'b0);
        n_checks++;
        if ({locked, err, err_cnt, phase_idx} !== {1'b0, 1'b1, 8'd2, 2'd2}) begin
            $display("FAIL ring_restart: got locked=%b err=%b cnt=%0d idx=%0d required 0/1/2/2", locked, err, err_cnt, phase_idx);
            n_fail++;
        end
        step(4'b0000, 1'b0, 1'b1);
        n_checks++;
        if ({err, err_cnt} !== {1'b0, 8'd2}) begin
            $display("FAIL err_clr: got err=%b cnt=%0d required 0/2", err, err_cnt);
            n_fail++;
        end
    endtask

    task automatic test_valid_gap();
        relock();
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            n_checks++;
            if ({locked, err, err_cnt, rev_cnt, phase_idx} !== {1'b1, 1'b0, 8'd2, 8'd2, 2'd0}) begin
                $display("FAIL gap_hold[%0d]: got %b required %b", i,
                         {locked, err, err_cnt, rev_cnt, phase_idx}, {1'b1, 1'b0, 8'd2, 8'd2, 2'd0});
                n_fail++;
            end
        end
        step(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if ({locked, err, phase_idx} !== {1'b1, 1'b0, 2'd1}) begin
            $display("FAIL gap_resume: got locked=%b err=%b idx=%0d required 1/0/1", locked, err, phase_idx);
            n_fail++;
        end
    endtask

    task automatic test_err_saturation();
        exp_err = 2;
        for (int i = 0; i < 254; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            n_checks++;
            if ({locked, err, err_cnt} !== {1'b0, 1'b1, 8'(exp_err)}) begin
                $display("FAIL err_sat[%0d]: got locked=%b err=%b cnt=%0d required 0/1/%0d", i, locked, err, err_cnt, exp_err);
                n_fail++;
            end
            step(4'b0000, 1'b0, 1'b0);
            relock();
        end
        n_checks++;
        if ({locked, err_cnt, rev_cnt} !== {1'b1, 8'd255, 8'd2}) begin
            $display("FAIL err_sat_end: got locked=%b cnt=%0d rev=%0d required 1/255/2", locked, err_cnt, rev_cnt);
            n_fail++;
        end
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b1, 1'b1);
        n_checks++;
        if ({locked, err, err_cnt} !== {1'b0, 1'b1, 8'd255}) begin
            $display("FAIL set_wins: got locked=%b err=%b cnt=%0d required 0/1/255", locked, err, err_cnt);
            n_fail++;
        end
        step(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_rev_wrap();
        relock();
        exp_rev = 2;
        for (int i = 0; i < 253; i++) begin
            step(4'b0010, 1'b1, 1'b0);
            step(4'b0100, 1'b1, 1'b0);
            step(4'b1000, 1'b1, 1'b0);
            step(4'b0001, 1'b1, 1'b0);
            exp_rev = (exp_rev + 1) % 256;
        end
        n_checks++;
        if ({locked, rev_cnt} !== {1'b1, 8'(exp_rev)}) begin
            $display("FAIL rev_255: got locked=%b rev=%0d required 1/%0d", locked, rev_cnt, exp_rev);
            n_fail++;
        end
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        n_checks++;
        if (rev_cnt !== 8'd255) begin
            $display("FAIL rev_midlap: got %0d required 255", rev_cnt); n_fail++;
        end
        step(4'b0001, 1'b1, 1'b0);
        n_checks++;
        if ({locked, rev_cnt} !== {1'b1, 8'd0}) begin
            $display("FAIL rev_wrap: got locked=%b rev=%0d required 1/0", locked, rev_cnt);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, err, err_cnt, rev_cnt, phase_idx} !== 19'd0) begin
            $display("FAIL async_rst: got %b required 0", {locked, err, err_cnt, rev_cnt, phase_idx});
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        relock();
        n_checks++;
        if ({locked, err, err_cnt, rev_cnt} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            $display("FAIL post_rst_lock: got locked=%b err=%b cnt=%0d rev=%0d required 1/0/0/0", locked, err, err_cnt, rev_cnt);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lock();
        test_bad_onehot();
        test_mid_reset();
        test_valid_gap();
        test_err_saturation();
        test_rev_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
